// File: rtl/aes_enc_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_enc_core
// Brief    : Iterative AES-128/192/256 encryptor, one round per clock, key
//            expanded on the fly. Optional debug ports: AES_ENC_CORE_DBG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_enc_core #(
   parameter int KEY_BITS = 128
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        din,
   input  logic [KEY_BITS-1:0] key_in,
   output logic                out_valid,
   input  logic                out_ready,
`ifdef AES_ENC_CORE_DBG_EN
   output logic [3:0]          dbg_round,
   output logic [1:0]          dbg_fsm,
`endif
   output logic [127:0]        dout
);

   localparam int c_NK = KEY_BITS / 32;
   localparam int c_NR = c_NK + 6;

   localparam logic [2047:0] c_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   generate
      if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("aes_enc_core: KEY_BITS must be 128, 192 or 256");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } fsm_t;

   function automatic logic [7:0] f_sbox(input logic [7:0] x);
      return c_SBOX[(255 - int'(x)) * 8 +: 8];
   endfunction

   function automatic logic [7:0] f_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] f_subword(input logic [31:0] w);
      return {f_sbox(w[31:24]), f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0])};
   endfunction

   fsm_t         r_fsm;
   fsm_t         w_fsm_next;
   logic         w_accept;
   logic         w_load;
   logic         w_step;
   logic         w_last;

   logic [127:0] r_state;
   logic [127:0] r_dout;
   logic [3:0]   r_round;
   logic [2:0]   r_phase;
   logic [7:0]   r_rcon;
   logic [31:0]  r_kw      [c_NK];
   logic [31:0]  w_kw_next [c_NK];
   logic [31:0]  w_new     [4];

   logic         w_sub_en;
   logic         w_rot;
   logic [1:0]   w_sub_pos;
   logic [3:0]   w_phase_sum;
   logic [2:0]   w_phase_next;
   logic [7:0]   w_rcon_next;

   logic [127:0] w_rk;
   logic [127:0] w_sr;
   logic [127:0] w_mc;
   logic [127:0] w_mid;
   logic [127:0] w_final;

   // Window r_kw holds w[4t .. 4t+Nk-1]; its first four words are round key t.
   // r_phase = 4t mod Nk locates the single SubWord inside the next group.
   always_comb begin : key_sched
      logic [31:0] w_acc;
      logic [31:0] w_sin;
      logic [31:0] w_rw;
      logic [31:0] w_tmp;
      logic [31:0] w_prev;
      logic [31:0] w_cur;
      w_sub_en  = 1'b1;
      w_sub_pos = 2'd0;
      w_rot     = (r_phase == 3'd0);
      if (c_NK == 6) begin
         w_rot = 1'b1;
         case (r_phase)
            3'd0:    w_sub_pos = 2'd0;
            3'd4:    w_sub_pos = 2'd2;
            default: w_sub_en  = 1'b0;
         endcase
      end
      // S-box input taken from an sbox-free prefix so the chain has no loop
      w_acc = r_kw[c_NK-1];
      w_sin = w_acc;
      for (int k = 0; k < 3; k++) begin
         w_acc = w_acc ^ r_kw[k];
         if (w_sub_pos == 2'(k + 1)) w_sin = w_acc;
      end
      w_rw  = w_rot ? {w_sin[23:0], w_sin[31:24]} : w_sin;
      w_tmp = f_subword(w_rw) ^ (w_rot ? {r_rcon, 24'h000000} : 32'h0);
      w_prev = r_kw[c_NK-1];
      for (int k = 0; k < 4; k++) begin
         w_cur    = r_kw[k] ^ ((w_sub_en && (w_sub_pos == 2'(k))) ? w_tmp : w_prev);
         w_new[k] = w_cur;
         w_prev   = w_cur;
      end
      w_phase_sum  = {1'b0, r_phase} + 4'd4;
      w_phase_next = (w_phase_sum >= 4'(c_NK)) ? 3'(w_phase_sum - 4'(c_NK)) : w_phase_sum[2:0];
      w_rcon_next  = (w_sub_en && w_rot) ? f_xtime(r_rcon) : r_rcon;
   end

   genvar gk;
   generate
      for (gk = 0; gk < c_NK; gk++) begin : g_win
         if (gk < c_NK - 4) begin : g_keep
            assign w_kw_next[gk] = r_kw[gk + 4];
         end else begin : g_fresh
            assign w_kw_next[gk] = w_new[gk - (c_NK - 4)];
         end
      end
   endgenerate

   always_comb begin : data_path
      logic [7:0] a0, a1, a2, a3;
      w_rk = {r_kw[0], r_kw[1], r_kw[2], r_kw[3]};
      w_sr = '0;
      for (int n = 0; n < 16; n++) begin
         w_sr[8*(15-n) +: 8] =
            f_sbox(r_state[8*(15 - (4*(((n/4) + (n%4)) % 4) + (n%4))) +: 8]);
      end
      w_mc = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = w_sr[8*(15-4*c) +: 8];
         a1 = w_sr[8*(14-4*c) +: 8];
         a2 = w_sr[8*(13-4*c) +: 8];
         a3 = w_sr[8*(12-4*c) +: 8];
         w_mc[8*(15-4*c) +: 8] = f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3;
         w_mc[8*(14-4*c) +: 8] = a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3;
         w_mc[8*(13-4*c) +: 8] = a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3;
         w_mc[8*(12-4*c) +: 8] = f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3);
      end
      w_mid   = w_mc ^ w_rk;
      w_final = w_sr ^ w_rk;
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) r_fsm <= S_IDLE;
      else       r_fsm <= w_fsm_next;
   end

   always_comb begin
      w_fsm_next = r_fsm;
      w_accept   = 1'b0;
      w_load     = 1'b0;
      w_step     = 1'b0;
      w_last     = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            if (in_valid) begin
               w_accept   = 1'b1;
               w_fsm_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_load     = 1'b1;
            w_fsm_next = S_ROUND;
         end
         S_ROUND: begin
            w_step = 1'b1;
            if (r_round == 4'(c_NR)) begin
               w_last     = 1'b1;
               w_fsm_next = S_DONE;
            end
         end
         default: begin
            if (out_ready) w_fsm_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= '0;
         r_dout  <= '0;
         r_round <= '0;
         r_phase <= '0;
         r_rcon  <= '0;
         for (int k = 0; k < c_NK; k++) r_kw[k] <= '0;
      end else begin
         if (w_accept) begin
            r_state <= din;
            r_round <= '0;
            r_phase <= '0;
            r_rcon  <= 8'h01;
            for (int k = 0; k < c_NK; k++) r_kw[k] <= key_in[KEY_BITS-1-32*k -: 32];
         end
         if (w_load) begin
            r_state <= r_state ^ w_rk;
            r_round <= 4'd1;
            r_kw    <= w_kw_next;
            r_phase <= w_phase_next;
            r_rcon  <= w_rcon_next;
         end
         if (w_step) begin
            if (w_last) begin
               r_dout <= w_final;
            end else begin
               r_state <= w_mid;
               r_round <= r_round + 4'd1;
               r_kw    <= w_kw_next;
               r_phase <= w_phase_next;
               r_rcon  <= w_rcon_next;
            end
         end
      end
   end

   assign in_ready  = (r_fsm == S_IDLE);
   assign out_valid = (r_fsm == S_DONE);
   assign dout      = r_dout;

`ifdef AES_ENC_CORE_DBG_EN
   assign dbg_round = (r_fsm == S_IDLE) ? 4'd0 : r_round;
   assign dbg_fsm   = r_fsm;
`endif

endmodule
`default_nettype wire

// File: doc/aes_enc_core.md
# aes_enc_core

Parametrised iterative AES encryption core covering AES-128, AES-192 and AES-256, selected at elaboration time. It performs one round per clock and expands the key on the fly, with no precomputed round-key table. Block and key enter through a valid/ready input handshake, and ciphertext leaves through a valid/ready output handshake with backpressure. It is the successor to the fixed AES-128 cipher and sits between the host register/DMA front end and the output buffer.

## Interface
- KEY_BITS, 128, key length; legal values are 128, 192 and 256. Any other value is an elaboration error. Nk = KEY_BITS/32, Nr = Nk+6.
- CLK  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; returns the FSM to IDLE.
- in_valid  input  1  din/key_in valid.
- in_ready  output  1  high only in IDLE; reset value 1 once the FSM is in IDLE.
- din  input  128  plaintext block, byte 0 = din[127:120] (FIPS-197 order).
- key_in  input  KEY_BITS  cipher key, word 0 = MSBs.
- out_valid  output  1  ciphertext valid; reset 0.
- out_ready  input  1  downstream accepts dout.
- dout  output  128  ciphertext; reset 0; held stable while out_valid && !out_ready.

## Operation
- FSM states and transitions:
  - IDLE → LOAD on in_valid && in_ready. The accept edge captures din into the state register and key_in into the key window.
  - LOAD → ROUND after one cycle. The state is XORed with round key 0 (w[0..3]); round counter r = 1.
  - ROUND: one round per cycle.
    - For r < Nr: SubBytes, ShiftRows, MixColumns, AddRoundKey(r), then r increments.
    - For r == Nr: SubBytes, ShiftRows, AddRoundKey(Nr); the result is written to dout, out_valid is set, and the FSM goes → DONE.
  - DONE: out_valid held. On out_valid && out_ready, clear out_valid and go → IDLE.
- Key schedule:
  - Round key r = w[4r..4r+3] per FIPS-197.
  - A sliding window of Nk words generates 4 new words per cycle, just in time for the next AddRoundKey.
  - RotWord/SubWord/Rcon are applied at i mod Nk == 0. For Nk = 8 only, SubWord alone is applied at i mod 8 == 4.
  - Each 4-word group contains at most one SubWord, so the key path uses exactly 4 S-box instances. The data path uses 16.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36, computed by GF(2^8) doubling. No table beyond index 10 is needed.
- Input capture:
  - din and key_in are sampled only on the accept edge.
  - Changes to din/key_in after acceptance have no effect on the block in flight.
- Ignored inputs:
  - in_valid outside IDLE is ignored; no queueing.
  - out_ready outside DONE is ignored.
- reset mid-operation: the FSM returns to IDLE immediately and out_valid/dout go to 0. The in-flight block is discarded and no partial result is ever presented.

## Timing
- Latency: out_valid rises Nr+1 cycles after the accept edge.
  - AES-128: 11 cycles.
  - AES-192: 13 cycles.
  - AES-256: 15 cycles.
- Minimum initiation interval: Nr+3 cycles, with out_ready tied high.
  - The DONE handshake cycle returns to IDLE.
  - in_ready rises the cycle after the output handshake.
- in_ready is a registered-state decode (fsm == IDLE) with no combinational path from in_valid or out_ready.
- out_ready may be held low indefinitely. dout and out_valid remain unchanged throughout.

## Configuration
- AES_ENC_CORE_DBG_EN defined:
  - Adds output dbg_round [3:0]: current r, 0 in IDLE/LOAD, Nr in DONE.
  - Adds output dbg_fsm [1:0]: IDLE = 0, LOAD = 1, ROUND = 2, DONE = 3.
  - Both reset to 0.
- AES_ENC_CORE_DBG_EN undefined: neither port exists, and the remaining logic is identical.

## Test plan
- AES-128 known answer: KEY_BITS = 128, key 000102…0f, din 00112233445566778899aabbccddeeff → dout 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 11 cycles after accept.
- AES-192 and AES-256 known answers:
  - KEY_BITS = 192, key 000102…17, same din → dda97ca4864cdfe06eaf70a0ec0d7191 at 13 cycles.
  - KEY_BITS = 256, key 000102…1f, same din → 8ea2b7ca516745bfeafc49904b496089 at 15 cycles.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid → dout stable and in_ready = 0 throughout. Pulse out_ready → out_valid drops next edge and in_ready = 1.
- Input isolation: hold in_valid high while busy and change din/key_in every cycle → only the accepted block is encrypted, and exactly one result is produced per accept.
- Reset mid-round: assert reset at round 5 → out_valid = 0 and dout = 0 immediately; in_ready = 1 after release. A new AES-128 vector then produces the correct result.
- Back-to-back throughput: 8 vectors with out_ready = 1 → all correct, initiation interval = Nr+3 cycles.
